// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// Definitions shared by the UART controllers: byte width, capture FSM encoding
// and the layout of one stored receive entry.
package uart_rx_fifo_ctrl_pkg;

  localparam int BYTE_W = 8;

  // The capture FSM has two states, held in a 1-bit register.
  localparam logic [0:0] ST_WAIT_RDY = 1'b0;
  localparam logic [0:0] ST_WAIT_LOW = 1'b1;

  typedef struct packed {
    logic              ferr;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_sync_fifo.sv
// Generic first-word-fall-through FIFO: the head entry is always visible on dout.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage is never reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + ONE_CNT;
        2'b01:   count_reg <= count_reg - ONE_CNT;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side controller: captures one byte per RX_READY pulse into a FWFT FIFO,
// applies the frame-error drop policy and tracks overruns and frame-error counts.
module uart_rx_fifo_ctrl
  import uart_rx_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_en,
  input  logic                   rx_ready,
  input  logic [BYTE_W-1:0]      dq,
  input  logic                   frame_error,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BYTE_W-1:0]      out_data,
  output logic                   out_ferr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  output logic [7:0]             err_cnt,
  input  logic                   clr_err
);

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic       capture;
  logic       cap_en;
  logic       err_event;
  logic       wr_req;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overrun_set;
  logic       overrun_reg;
  logic [7:0] err_cnt_reg;
  rx_entry_t  wr_entry;
  rx_entry_t  head_entry;

  // A capture happens only on the first cycle of a ready level, never while it is held.
  assign capture = (state_reg == ST_WAIT_RDY) && rx_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT_RDY: if (rx_ready)  state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!rx_ready) state_next = ST_WAIT_RDY;
      default:     state_next = ST_WAIT_RDY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_WAIT_RDY;
    end else begin
      state_reg <= state_next;
    end
  end

  assign cap_en      = capture & rx_en;
  assign err_event   = cap_en & frame_error;
  assign wr_req      = cap_en & ~(frame_error & DROP_ERR);
  assign pop         = out_valid & out_ready;
  assign overrun_set = wr_req & fifo_full & ~pop;
  assign wr_entry    = '{ferr: frame_error, data: dq};

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_req),
    .din   (wr_entry),
    .pop   (out_ready),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Clearing wins over a same-cycle set or increment.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      overrun_reg <= 1'b0;
      err_cnt_reg <= 8'd0;
    end else begin
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end
      if (err_event) begin
        err_cnt_reg <= sat_inc8(err_cnt_reg);
      end
    end
  end

  assign out_valid = ~fifo_empty;
  assign out_data  = head_entry.data;
  assign out_ferr  = head_entry.ferr;
  assign overrun   = overrun_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: doc/uart_rx_fifo_ctrl.md
# uart_rx_fifo_ctrl

Receive-side controller for the UART receiver. It watches the receiver's ready/data/frame-error outputs and captures exactly one byte per received frame into a small first-word-fall-through FIFO. It applies the frame-error policy and flags overruns. It presents bytes to the host logic over a valid/ready handshake, sitting between the receiver top level and any consumer.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- DROP_ERR, 0: 1 = discard bytes received with FRAME_ERROR; 0 = store them with their error bit.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- RX_EN  in  1  capture enable; 0 = frames are ignored (not stored, not counted).
- RX_READY  in  1  receiver byte-ready level, CLK-synchronous.
- DQ  in  8  receiver data, valid while RX_READY=1.
- FRAME_ERROR  in  1  receiver frame error, valid while RX_READY=1.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  consumer accepts head entry when OUT_VALID=1.
- OUT_DATA  out  8  head byte (mem[rd_ptr]).
- OUT_FERR  out  1  head byte's stored frame-error bit.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.
- OVERRUN  out  1  sticky: a byte was lost because the FIFO was full.
- ERR_CNT  out  8  saturating count of frame errors seen.
- CLR_ERR  in  1  clears OVERRUN and ERR_CNT.

## Operation
- Capture FSM, states WAIT_RDY, WAIT_LOW; reset state WAIT_RDY.
  - WAIT_RDY: RX_READY=1 → capture event this cycle, go WAIT_LOW.
  - WAIT_LOW: RX_READY=0 → WAIT_RDY. No capture while in WAIT_LOW, so a level held for many cycles yields one byte.
- Capture event with RX_EN=1:
  - If FRAME_ERROR=1, ERR_CNT increments, saturating at 255.
  - The byte is dropped if FRAME_ERROR=1 and DROP_ERR=1.
  - Otherwise it is written as {FRAME_ERROR, DQ}.
- Capture event with RX_EN=0: the FSM still advances to WAIT_LOW; no write and no count.
- Write allowed when COUNT<DEPTH, or when COUNT=DEPTH and a pop occurs in the same cycle. Otherwise the byte is discarded and OVERRUN is set.
- Pop happens when OUT_VALID & OUT_READY. OUT_READY is ignored when the FIFO is empty.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. COUNT updates by +1 on write only, -1 on pop only, and is unchanged on both or neither.
- CLR_ERR has priority over a same-cycle set or increment: both flags read 0 the next cycle.
- The FIFO contents are not cleared by CLR_ERR.

## Timing
- Reset values: OUT_VALID=0, COUNT=0, OVERRUN=0, ERR_CNT=0, FSM=WAIT_RDY, pointers=0. OUT_DATA and OUT_FERR are don't-care while OUT_VALID=0.
- RST mid-frame: everything returns to reset values next cycle.
  - If RX_READY is still high after reset, the FSM captures it again, because the reset state is WAIT_RDY.
- Capture latency: RX_READY rises in cycle n with an empty FIFO → OUT_VALID=1 and OUT_DATA=DQ(n) in cycle n+1.
- Pop in cycle m → the next entry, or OUT_VALID=0, appears in cycle m+1.
- Back-to-back frames need RX_READY low for ≥1 cycle between them.
- OVERRUN asserts the cycle after the dropped capture.
- ERR_CNT increments the cycle after the error capture.

## Structure
- Shared UART package: byte width constant (8) and FSM state encoding (2 states, 1 bit), reused by the TX-side controller.
- One sub-module, `uart_sync_fifo`: generic FWFT FIFO (WIDTH, DEPTH) with push/pop/full/empty/count. The controller wraps it with the FSM, policy and error registers.

## Test plan
- Single byte: RX_READY high 5 cycles, DQ=0xA5, FRAME_ERROR=0 → exactly one entry; OUT_VALID next cycle, OUT_DATA=0xA5, OUT_FERR=0, COUNT=1; pop → COUNT=0.
- Fill/overrun (DEPTH=8, OUT_READY=0): 9 frames 0x00..0x08 → COUNT=8, OVERRUN=1; draining yields 0x00..0x07 in order; CLR_ERR → OVERRUN=0.
- Full with simultaneous pop: FIFO full, OUT_READY=1 in the capture cycle of 0x55 → COUNT stays 8, OVERRUN stays 0, 0x55 is last out.
- Frame errors: DROP_ERR=0, frame 0x3C with FRAME_ERROR=1 → stored, OUT_FERR=1, ERR_CNT=1. DROP_ERR=1, same frame → COUNT=0, ERR_CNT=1. 300 error frames → ERR_CNT=255.
- RX_EN=0: 3 frames → COUNT=0, ERR_CNT=0. Then RX_EN=1 with RX_READY already high → no capture until RX_READY falls and rises again.
- Reset mid-operation: COUNT=4, OVERRUN=1, RST for 1 cycle → all outputs at reset values next cycle; RX_READY held high through reset → one capture after reset.
